// File: rtl/perf_pkg.sv
// perf_pkg: shared widths, report length and FSM states for perf_report (checksum byte under PERF_REPORT_CKSUM_EN)
package perf_pkg;
  localparam int CNT_W = 16;
  localparam int BYTE_W = 8;
`ifdef PERF_REPORT_CKSUM_EN
  localparam int RPT_BYTES = 5;
`else
  localparam int RPT_BYTES = 4;
`endif
  localparam logic [2:0] LAST_IDX = 3'(RPT_BYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, SETTLE, SEND} state_t;
endpackage

// File: rtl/perf_report_if.sv
// perf_report_if: valid/ready byte stream towards the serial transmitter
interface perf_report_if;
  import perf_pkg::*;
  logic [BYTE_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, output tx_valid, input tx_ready);
  modport slave(input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/perf_tx_ser.sv
// perf_tx_ser: snapshots the counts on i_load and streams them MSB-first over valid/ready
// PERF_REPORT_CKSUM_EN appends an XOR checksum byte
module perf_tx_ser
  import perf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_instr,
  input  logic [CNT_W-1:0] i_cycle,
  output logic             o_done,
  perf_report_if.master    tx
);
  logic [CNT_W-1:0] r_instr, r_cycle;
  logic [2:0] r_idx;
  logic r_valid;
  logic w_acc;
  logic [BYTE_W-1:0] w_byte;
  assign w_acc = r_valid & tx.tx_ready;
  assign o_done = w_acc && r_idx == LAST_IDX;
`ifdef PERF_REPORT_CKSUM_EN
  logic [BYTE_W-1:0] w_ck;
  assign w_ck = r_instr[15:8] ^ r_instr[7:0] ^ r_cycle[15:8] ^ r_cycle[7:0];
  assign w_byte = r_idx == 3'd0 ? r_instr[15:8] :
                  r_idx == 3'd1 ? r_instr[7:0] :
                  r_idx == 3'd2 ? r_cycle[15:8] :
                  r_idx == 3'd3 ? r_cycle[7:0] : w_ck;
`else
  assign w_byte = r_idx == 3'd0 ? r_instr[15:8] :
                  r_idx == 3'd1 ? r_instr[7:0] :
                  r_idx == 3'd2 ? r_cycle[15:8] : r_cycle[7:0];
`endif
  assign tx.tx_data = w_byte;
  assign tx.tx_valid = r_valid;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_instr <= '0;
      r_cycle <= '0;
      r_idx <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_cycle <= i_cycle;
      r_idx <= '0;
      r_valid <= 1'b1;
    end else if (w_acc) begin
      r_valid <= r_idx != LAST_IDX;
      r_idx <= r_idx == LAST_IDX ? r_idx : r_idx + 3'd1;
    end
endmodule

// File: rtl/perf_report.sv
// perf_report: turns host start/stop pulses into counter strobes and reports the frozen counts
// report length set by PERF_REPORT_CKSUM_EN in perf_pkg
module perf_report
  import perf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic [CNT_W-1:0] instr_cnt,
  input  logic [CNT_W-1:0] cycle_cnt,
  output logic             str_icnt,
  output logic             str_ccnt,
  output logic             stp_cnt,
  output logic             busy,
  perf_report_if.master    tx
);
  state_t r_state, w_next;
  logic r_str, r_stp;
  logic w_str, w_stp, w_load, w_done;
  assign str_icnt = r_str;
  assign str_ccnt = r_str;
  assign stp_cnt = r_stp;
  assign busy = r_state == SETTLE || r_state == SEND;
  // RUN lingers one cycle with the stop strobe out so the counter's last increment lands before SETTLE
  always_comb begin
    w_next = r_state;
    w_str = 1'b0;
    w_stp = 1'b0;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        w_str = cmd_start;
        w_next = cmd_start ? RUN : IDLE;
      end
      RUN: begin
        w_stp = cmd_stop & ~r_stp;
        w_next = r_stp ? SETTLE : RUN;
      end
      SETTLE: begin
        w_load = 1'b1;
        w_next = SEND;
      end
      default: w_next = w_done ? IDLE : SEND;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_str <= 1'b0;
      r_stp <= 1'b0;
    end else begin
      r_state <= w_next;
      r_str <= w_str;
      r_stp <= w_stp;
    end
  perf_tx_ser u_ser (
    .clk(clk),
    .rst(rst),
    .i_load(w_load),
    .i_instr(instr_cnt),
    .i_cycle(cycle_cnt),
    .o_done(w_done),
    .tx(tx)
  );
endmodule

// File: tb/tb_perf_report.sv
// tb_perf_report: randomized and directed checks of perf_report against a byte-queue reference model
module tb_perf_report;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_start = 1'b0, cmd_stop = 1'b0;
  logic [15:0] instr_cnt = '0, cycle_cnt = '0;
  logic str_icnt, str_ccnt, stp_cnt, busy;
  bit rand_cnt = 0, rand_rdy = 0;
  int n_chk = 0, n_pass = 0;
  byte unsigned cap[$];
  perf_report_if tx_if ();
  perf_report dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt), .str_icnt(str_icnt),
    .str_ccnt(str_ccnt), .stp_cnt(stp_cnt), .busy(busy), .tx(tx_if.master)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask
  // model: 0 idle, 1 run, 2 stop issued, 3 settle, 4 send
  int mode = 0;
  bit e_str = 0, e_stp = 0;
  byte unsigned q[$];
  always @(posedge clk or negedge rst)
    if (!rst) begin
      mode = 0; q.delete(); e_str = 0; e_stp = 0;
    end else begin
      e_str = 0; e_stp = 0;
      case (mode)
        0: if (cmd_start) begin e_str = 1; mode = 1; end
        1: if (cmd_stop) begin e_stp = 1; mode = 2; end
        2: mode = 3;
        3: begin
          q = '{instr_cnt[15:8], instr_cnt[7:0], cycle_cnt[15:8], cycle_cnt[7:0]};
`ifdef PERF_REPORT_CKSUM_EN
          q.push_back(instr_cnt[15:8] ^ instr_cnt[7:0] ^ cycle_cnt[15:8] ^ cycle_cnt[7:0]);
`endif
          mode = 4;
        end
        default: if (tx_if.tx_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) mode = 0;
        end
      endcase
    end
  always @(negedge clk) begin
    logic ev;
    ev = mode == 4;
    chk("cycle", {str_icnt, str_ccnt, stp_cnt, tx_if.tx_valid, busy, tx_if.tx_valid ? tx_if.tx_data : 8'h00},
        {e_str, e_str, e_stp, ev, mode >= 3, ev ? q[0] : 8'h00});
    if (tx_if.tx_valid && tx_if.tx_ready) cap.push_back(tx_if.tx_data);
  end
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_cnt) begin instr_cnt = 16'($urandom); cycle_cnt = 16'($urandom); end
      if (rand_rdy) tx_ready_set($urandom % 3 != 0);
    end
  endtask
  task automatic tx_ready_set(bit v);
    tx_if.tx_ready = v;
  endtask
  task automatic pulse(bit s, bit p);
    cmd_start = s; cmd_stop = p; cyc(1); cmd_start = 0; cmd_stop = 0;
  endtask
  task automatic wait_idle();
    int i = 0;
    cyc(2);
    while (busy && i < 300) begin cyc(1); i++; end
    chk("timeout", i < 300, 1);
  endtask
  task automatic wait_valid();
    int i = 0;
    while (!tx_if.tx_valid && i < 20) begin cyc(1); i++; end
    chk("valid_timeout", i < 20, 1);
  endtask
  task automatic chk_cap(string name);
    byte unsigned exp[$];
    exp = '{8'h12, 8'h34, 8'h00, 8'hAB};
`ifdef PERF_REPORT_CKSUM_EN
    exp.push_back(8'h8D);
`endif
    chk({name, "_len"}, cap.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap.size(); i++) chk(name, cap[i], exp[i]);
  endtask
  initial begin
    tx_if.tx_ready = 1'b1;
    #12;
    chk("rst_out", {str_icnt, str_ccnt, stp_cnt, tx_if.tx_valid, busy, tx_if.tx_data}, 0);
    @(posedge clk); #3 rst = 1'b1;
    cyc(2);
    instr_cnt = 16'h1234; cycle_cnt = 16'h00AB;
    pulse(1, 0);
    chk("start_strb", {str_icnt, str_ccnt, stp_cnt, busy}, 4'b1100);
    cyc(1);
    chk("start_once", {str_icnt, str_ccnt}, 2'b00);
    cyc(3);
    cap.delete();
    pulse(0, 1);
    chk("stop_strb", {stp_cnt, busy}, 2'b10);
    wait_idle();
    chk_cap("bytes");
    pulse(1, 0); cyc(2); cap.delete(); pulse(0, 1);
    wait_valid();
    cyc(1);
    tx_ready_set(0);
    repeat (5) begin cyc(1); chk("stall", {tx_if.tx_valid, tx_if.tx_data}, 9'h134); end
    tx_ready_set(1);
    wait_idle();
    chk_cap("stall_seq");
    pulse(1, 1);
    chk("both_cmd", {str_icnt, str_ccnt, stp_cnt}, 3'b110);
    cyc(2); cap.delete();
    pulse(0, 1);
    chk("run_stop", stp_cnt, 1);
    cyc(2); pulse(1, 0); pulse(0, 1); pulse(1, 1);
    wait_idle();
    chk_cap("busy_cmds");
    pulse(1, 0); pulse(0, 1);
    wait_valid(); cyc(2);
    #1 rst = 1'b0;
    #1 chk("rst_mid", {tx_if.tx_valid, busy, tx_if.tx_data}, 0);
    cyc(1); #1 rst = 1'b1;
    cyc(1); cap.delete();
    pulse(1, 0); cyc(1); pulse(0, 1);
    wait_idle();
    chk_cap("fresh");
    rand_cnt = 1; rand_rdy = 1;
    for (int i = 0; i < 4000; i++) begin
      cmd_start = $urandom % 6 == 0;
      cmd_stop = $urandom % 5 == 0;
      cyc(1);
    end
    cmd_start = 0; cmd_stop = 0;
    cyc(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
